ram_dma_copy: RTL and testbench

Initiator-side engine that drives the word-addressed scratch RAM port (ce/we/addr/data, 32-bit big-endian words, combinational read) on behalf of a controller. Accepts one command at a time, either a word block copy (src -> dst) or a constant fill of dst, and sequences the RAM accesses itself. It sits between a control register block and the RAM, and is the RAM's only master when active.

---
 rtl/ram_dma_pkg.sv | 16 +
 rtl/ram_dma_copy_if.sv | 13 +
 rtl/ram_dma_range_chk.sv | 24 ++
 rtl/ram_dma_copy.sv | 147 ++++++++++++++
 tb/tb_ram_dma_copy.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/ram_dma_pkg.sv
// Shared types and constants for the scratch-RAM DMA copy/fill engine.
package ram_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_RD    = 3'd2,
        ST_WR    = 3'd3,
        ST_FIN   = 3'd4
    } state_e;

    localparam logic OP_COPY    = 1'b0;
    localparam logic OP_FILL    = 1'b1;
    localparam int   WORD_BYTES = 4;

endpackage

// File: rtl/ram_dma_copy_if.sv
// Word-addressed scratch RAM port: chip enable, write enable, byte address, data.
interface ram_dma_copy_if #(
    parameter int XLEN = 32
);
    logic            ce;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] rdata;

    modport master (output ce, output we, output addr, output wdata, input rdata);
    modport slave  (input ce, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/ram_dma_range_chk.sv
// Combinational alignment and bounds check for one (byte address, word count) pair.
module ram_dma_range_chk
    import ram_dma_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int LEN_W    = 8,
    parameter int MEM_SIZE = 32
) (
    input  logic [XLEN-1:0]  addr,
    input  logic [LEN_W-1:0] len,
    output logic             ok
);

    // Wide enough that addr + 4*len can never wrap.
    localparam int SUM_W = XLEN + LEN_W + 2;

    logic [SUM_W-1:0] end_addr;
    logic             aligned;

    assign end_addr = SUM_W'(addr) + (SUM_W'(len) << 2);
    assign aligned  = (addr[1:0] == 2'b00);
    assign ok       = aligned && (end_addr <= SUM_W'(MEM_SIZE));

endmodule

// File: rtl/ram_dma_copy.sv
// Copy/fill DMA engine: sequences RD/WR word accesses on the scratch RAM for one command at a time.
module ram_dma_copy
    import ram_dma_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MEM_SIZE = 32,
    parameter int LEN_W    = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             op_i,
    input  logic [XLEN-1:0]  src_i,
    input  logic [XLEN-1:0]  dst_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [XLEN-1:0]  fill_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    ram_dma_copy_if.master   ram
);

    state_e           state_q, state_d;
    logic             op_q, op_d;
    logic [XLEN-1:0]  fill_q, fill_d;
    logic [XLEN-1:0]  src_ptr_q, src_ptr_d;
    logic [XLEN-1:0]  dst_ptr_q, dst_ptr_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [XLEN-1:0]  buf_q, buf_d;
    logic             err_flag_q, err_flag_d;
    logic             src_ok, dst_ok;

    logic             busy_d, done_d, err_d, ce_d, we_d;
    logic [XLEN-1:0]  addr_d, wdata_d;

    ram_dma_range_chk #(.XLEN(XLEN), .LEN_W(LEN_W), .MEM_SIZE(MEM_SIZE)) u_src_chk (
        .addr (src_ptr_q),
        .len  (rem_q),
        .ok   (src_ok)
    );

    ram_dma_range_chk #(.XLEN(XLEN), .LEN_W(LEN_W), .MEM_SIZE(MEM_SIZE)) u_dst_chk (
        .addr (dst_ptr_q),
        .len  (rem_q),
        .ok   (dst_ok)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        fill_d     = fill_q;
        src_ptr_d  = src_ptr_q;
        dst_ptr_d  = dst_ptr_q;
        rem_d      = rem_q;
        buf_d      = buf_q;
        err_flag_d = err_flag_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d    = ST_CHECK;
                    op_d       = op_i;
                    fill_d     = fill_i;
                    src_ptr_d  = src_i;
                    dst_ptr_d  = dst_i;
                    rem_d      = len_i;
                    err_flag_d = 1'b0;
                end
            end
            ST_CHECK: begin
                if (!dst_ok || (op_q == OP_COPY && !src_ok)) begin
                    err_flag_d = 1'b1;
                    state_d    = ST_FIN;
                end else if (rem_q == '0) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = (op_q == OP_COPY) ? ST_RD : ST_WR;
                end
            end
            ST_RD: begin
                buf_d   = ram.rdata;
                state_d = ST_WR;
            end
            ST_WR: begin
                src_ptr_d = src_ptr_q + XLEN'(WORD_BYTES);
                dst_ptr_d = dst_ptr_q + XLEN'(WORD_BYTES);
                rem_d     = rem_q - 1'b1;
                if (rem_q == LEN_W'(1)) state_d = ST_FIN;
                else                    state_d = (op_q == OP_COPY) ? ST_RD : ST_WR;
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered, so derive them from the state being entered.
        busy_d  = (state_d == ST_CHECK) || (state_d == ST_RD) || (state_d == ST_WR);
        done_d  = (state_d == ST_FIN);
        err_d   = (state_d == ST_FIN) && err_flag_d;
        ce_d    = (state_d == ST_RD) || (state_d == ST_WR);
        we_d    = (state_d == ST_WR);
        addr_d  = '0;
        wdata_d = '0;
        if (state_d == ST_RD) begin
            addr_d = src_ptr_d;
        end else if (state_d == ST_WR) begin
            addr_d  = dst_ptr_d;
            wdata_d = (op_d == OP_FILL) ? fill_d : buf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_COPY;
            fill_q     <= '0;
            src_ptr_q  <= '0;
            dst_ptr_q  <= '0;
            rem_q      <= '0;
            buf_q      <= '0;
            err_flag_q <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            ram.ce     <= 1'b0;
            ram.we     <= 1'b0;
            ram.addr   <= '0;
            ram.wdata  <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            fill_q     <= fill_d;
            src_ptr_q  <= src_ptr_d;
            dst_ptr_q  <= dst_ptr_d;
            rem_q      <= rem_d;
            buf_q      <= buf_d;
            err_flag_q <= err_flag_d;
            busy_o     <= busy_d;
            done_o     <= done_d;
            err_o      <= err_d;
            ram.ce     <= ce_d;
            ram.we     <= we_d;
            ram.addr   <= addr_d;
            ram.wdata  <= wdata_d;
        end
    end

endmodule

// File: tb/tb_ram_dma_copy.sv
// Scoreboard bench for ram_dma_copy against a 32-byte behavioural scratch RAM.
module tb_ram_dma_copy;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] src = '0, dst = '0, fill = '0;
    logic [7:0]  len = '0;
    logic        busy, done, err;

    ram_dma_copy_if #(.XLEN(32)) ram ();

    ram_dma_copy #(.XLEN(32), .MEM_SIZE(32), .LEN_W(8)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .op_i    (op),
        .src_i   (src),
        .dst_i   (dst),
        .len_i   (len),
        .fill_i  (fill),
        .busy_o  (busy),
        .done_o  (done),
        .err_o   (err),
        .ram     (ram)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: combinational read, write on rising edge, plus a bench preload port.
    logic [31:0] mem [8];
    logic        pl_en = 1'b0;
    logic [2:0]  pl_idx = '0;
    logic [31:0] pl_dat = '0;

    assign ram.rdata = mem[ram.addr[4:2]];

    always @(posedge clk) begin
        if (pl_en)                 mem[pl_idx] <= pl_dat;
        else if (ram.ce && ram.we) mem[ram.addr[4:2]] <= ram.wdata;
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    acc_t        exp_q [$];
    logic [31:0] model [8];
    int          n_chk = 0;
    int          n_fail = 0;
    int          done_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every RAM access must match the next expected access in order.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (ram.ce) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_access", {31'd0, ram.we, ram.addr}, 64'd0);
            end else begin
                acc_t a;
                a = exp_q.pop_front();
                chk("acc_we",   {63'd0, ram.we}, {63'd0, a.we});
                chk("acc_addr", {32'd0, ram.addr}, {32'd0, a.addr});
                chk("acc_data", {32'd0, ram.wdata}, {32'd0, a.data});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        pl_en  = 1'b1;
        pl_idx = idx[2:0];
        pl_dat = val;
        step();
        pl_en  = 1'b0;
        model[idx] = val;
    endtask

    task automatic push_expected(input logic cop, input logic [31:0] s, input logic [31:0] d,
                                 input int n, input logic [31:0] f);
        for (int i = 0; i < n; i++) begin
            logic [31:0] w;
            if (cop == 1'b0) begin
                exp_q.push_back('{we: 1'b0, addr: s + 32'(4 * i), data: 32'd0});
                w = model[(s >> 2) + i];
            end else begin
                w = f;
            end
            exp_q.push_back('{we: 1'b1, addr: d + 32'(4 * i), data: w});
            model[(d >> 2) + i] = w;
        end
    endtask

    task automatic run_cmd(input string tag, input logic cop, input logic [31:0] s,
                           input logic [31:0] d, input int n, input logic [31:0] f,
                           input logic exp_err, input bit repulse);
        int  lat_exp;
        int  k;
        int  d0;
        bit  seen;
        logic err_seen;
        lat_exp = (exp_err || n == 0) ? 2 : (cop ? 2 + n : 2 + 2 * n);
        if (!exp_err) push_expected(cop, s, d, n, f);
        d0 = done_cnt;
        op = cop; src = s; dst = d; len = n[7:0]; fill = f;
        start = 1'b1;
        step();
        start = 1'b0;
        op = ~cop; src = 32'h4; dst = 32'h0; len = 8'd1; fill = 32'hDEAD_BEEF;
        chk({tag, "_busy_check"}, {63'd0, busy}, 64'd1);
        seen = 1'b0;
        err_seen = 1'b0;
        for (k = 1; k <= 300; k++) begin
            if (done) begin
                seen = 1'b1;
                err_seen = err;
                break;
            end
            start = (repulse && k == 3);
            step();
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
        if (repulse && seen) begin
            start = 1'b1;
            step();
            start = 1'b0;
        end
        chk({tag, "_latency"}, 64'(k), 64'(lat_exp));
        chk({tag, "_err"}, {63'd0, err_seen}, {63'd0, exp_err});
        repeat (4) step();
        chk({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
        chk({tag, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 8; i++) model[i] = '0;
        repeat (3) step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) preload(i, 32'd0);
        chk("rst_busy",  {63'd0, busy}, 64'd0);
        chk("rst_done",  {63'd0, done}, 64'd0);
        chk("rst_err",   {63'd0, err}, 64'd0);
        chk("rst_ce",    {63'd0, ram.ce}, 64'd0);
        chk("rst_we",    {63'd0, ram.we}, 64'd0);
        chk("rst_addr",  {32'd0, ram.addr}, 64'd0);
        chk("rst_wdata", {32'd0, ram.wdata}, 64'd0);

        run_cmd("fill3", 1'b1, 32'h0, 32'h08, 3, 32'hA5A5_0001, 1'b0, 1'b0);

        preload(0, 32'h1122_3344);
        preload(1, 32'h5566_7788);
        run_cmd("copy2", 1'b0, 32'h00, 32'h18, 2, 32'h0, 1'b0, 1'b0);

        run_cmd("err_dst_align", 1'b1, 32'h0, 32'h06, 1, 32'h1234, 1'b1, 1'b0);
        run_cmd("err_src_bound", 1'b0, 32'h10, 32'h00, 5, 32'h0, 1'b1, 1'b0);
        run_cmd("err_src_align", 1'b0, 32'h02, 32'h00, 1, 32'h0, 1'b1, 1'b0);
        run_cmd("len0_fill",     1'b1, 32'h0, 32'h04, 0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_cmd("fill_last_word", 1'b1, 32'h0, 32'h1C, 1, 32'hCAFE_0007, 1'b0, 1'b0);
        run_cmd("err_dst_bound", 1'b1, 32'h0, 32'h1C, 2, 32'hCAFE_0008, 1'b1, 1'b0);
        run_cmd("err_len_max",   1'b1, 32'h0, 32'h00, 255, 32'h0, 1'b1, 1'b0);

        // Reset in the second WR cycle of a 4-word copy: only two words land.
        preload(0, 32'h0BAD_0000);
        preload(1, 32'h0BAD_0001);
        preload(2, 32'h0BAD_0002);
        preload(3, 32'h0BAD_0003);
        push_expected(1'b0, 32'h00, 32'h10, 2, 32'h0);
        d0 = done_cnt;
        op = 1'b0; src = 32'h00; dst = 32'h10; len = 8'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < 5; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid_ce",   {63'd0, ram.ce}, 64'd0);
        chk("rstmid_busy", {63'd0, busy}, 64'd0);
        chk("rstmid_done", {63'd0, done}, 64'd0);
        chk("rstmid_addr", {32'd0, ram.addr}, 64'd0);
        repeat (4) step();
        chk("rstmid_no_done", 64'(done_cnt - d0), 64'd0);
        chk("rstmid_queue",   64'(exp_q.size()), 64'd0);

        run_cmd("fill_after_rst", 1'b1, 32'h0, 32'h00, 8, 32'h7777_0000, 1'b0, 1'b0);

        preload(0, 32'h0000_000A);
        preload(1, 32'h0000_000B);
        preload(2, 32'h0000_000C);
        preload(3, 32'h0000_000D);
        run_cmd("copy_busy_restart", 1'b0, 32'h00, 32'h10, 3, 32'h0, 1'b0, 1'b1);

        run_cmd("copy_overlap", 1'b0, 32'h00, 32'h04, 3, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("smear_word%0d", i), {32'd0, mem[i]}, 64'h0000_000A);

        for (int i = 0; i < 8; i++)
            chk($sformatf("ram_word%0d", i), {32'd0, mem[i]}, {32'd0, model[i]});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
